// File: rtl/pll_pkg.sv
// Shared PLL monitor definitions: FSM encoding, measurement width, default thresholds.
package pll_pkg;

  localparam int MEAS_W       = 7;
  localparam int LOCK_CNT_DEF = 8;
  localparam int MISS_CNT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACQ  = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
    return (&v) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/fb_edge_sync.sv
// Two-flop synchronizer for an asynchronous clock-like input, plus a delay
// flop for single-cycle rise/fall strobes. Reusable for the reference path.
module fb_edge_sync (
  input  logic clk,
  input  logic rstn_s,
  input  logic d,
  output logic d_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic d_d;

  // Synchronizer chain followed by the edge-detect delay stage.
  always_ff @(posedge clk or negedge rstn_s) begin
    if (!rstn_s) begin
      meta <= 1'b0;
      d_s  <= 1'b0;
      d_d  <= 1'b0;
    end else begin
      meta <= d;
      d_s  <= meta;
      d_d  <= d_s;
    end
  end

  assign rise = d_s & ~d_d;
  assign fall = ~d_s & d_d;

endmodule

// File: rtl/loop_div_monitor.sv
// Loop-divider output checker: measures period and high time of the divided
// clock in clk cycles, compares against div_n, and tracks lock.
module loop_div_monitor
  import pll_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int MISS_CNT = MISS_CNT_DEF
) (
  input  logic              clk,
  input  logic              rstn_s,
  input  logic              en,
  input  logic [5:0]        div_n,
  input  logic              fb_in,
  output logic              locked,
  output logic              meas_valid,
  output logic [MEAS_W-1:0] meas_period,
  output logic [MEAS_W-1:0] meas_high,
  output logic              err_period,
  output logic              err_timeout,
  output logic              cfg_err,
  output logic [1:0]        state
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [1:0] MISS_LAST = 2'(MISS_CNT - 1);

  logic fb_s, rise, fall;

  state_t state_q, state_nxt;

  logic [5:0]        div_q;
  logic [5:0]        hi_exp6;
  logic [MEAS_W-1:0] exp_period, exp_high, tmo;
  logic [MEAS_W-1:0] per_cnt, hi_cnt;
  logic              hi_ok;
  logic [3:0]        good_cnt;
  logic [1:0]        bad_cnt;

  logic cfg_bad, div_chg, active, timeout, period_good;
  logic clr_all, restart, arm, eval, tmo_hit;

  fb_edge_sync u_fb_sync (
    .clk    (clk),
    .rstn_s (rstn_s),
    .d      (fb_in),
    .d_s    (fb_s),
    .rise   (rise),
    .fall   (fall)
  );

  // Expected values derived from the programmed ratio; high phase takes the odd cycle.
  assign hi_exp6     = div_n - (div_n >> 1);
  assign exp_period  = {1'b0, div_n};
  assign exp_high    = {1'b0, hi_exp6};
  assign tmo         = {div_n, 1'b0};

  assign cfg_bad     = (div_n < 6'd2);
  assign div_chg     = (div_n != div_q);
  assign active      = (state_q == ST_ACQ) || (state_q == ST_LOCK);
  assign timeout     = active && (per_cnt == tmo);
  assign period_good = (per_cnt == exp_period) && hi_ok;

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rstn_s) begin
    if (!rstn_s) state_q <= ST_IDLE;
    else         state_q <= state_nxt;
  end

  // Next state and event strobes; priority: enable/config, div change, timeout, rise.
  always_comb begin
    state_nxt = state_q;
    clr_all   = 1'b0;
    restart   = 1'b0;
    arm       = 1'b0;
    eval      = 1'b0;
    tmo_hit   = 1'b0;
    if (!en || cfg_bad) begin
      state_nxt = ST_IDLE;
      clr_all   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (div_chg) begin
            restart = 1'b1;
          end else if (rise) begin
            arm       = 1'b1;
            state_nxt = ST_ACQ;
          end
        end
        default: begin
          if (div_chg) begin
            restart   = 1'b1;
            state_nxt = ST_WAIT;
          end else if (timeout) begin
            tmo_hit   = 1'b1;
            restart   = 1'b1;
            state_nxt = ST_WAIT;
          end else if (rise) begin
            eval = 1'b1;
            if (state_q == ST_ACQ && period_good && good_cnt == LOCK_LAST)
              state_nxt = ST_LOCK;
            else if (state_q == ST_LOCK && !period_good && bad_cnt == MISS_LAST)
              state_nxt = ST_ACQ;
          end
        end
      endcase
    end
  end

  // Measurement counters, lock counters and registered status outputs.
  always_ff @(posedge clk or negedge rstn_s) begin
    if (!rstn_s) begin
      div_q       <= '0;
      cfg_err     <= 1'b0;
      locked      <= 1'b0;
      meas_valid  <= 1'b0;
      err_period  <= 1'b0;
      err_timeout <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      hi_ok       <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      div_q       <= div_n;
      cfg_err     <= cfg_bad;
      locked      <= (state_nxt == ST_LOCK);
      meas_valid  <= eval;
      err_period  <= eval & ~period_good;
      err_timeout <= tmo_hit;
      if (clr_all) begin
        per_cnt     <= '0;
        hi_cnt      <= '0;
        hi_ok       <= 1'b0;
        good_cnt    <= '0;
        bad_cnt     <= '0;
        meas_period <= '0;
        meas_high   <= '0;
      end else if (restart || state_q == ST_IDLE) begin
        per_cnt  <= '0;
        hi_cnt   <= '0;
        hi_ok    <= 1'b0;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (state_q == ST_WAIT) begin
        if (arm) begin
          per_cnt  <= 7'd1;
          hi_cnt   <= 7'd1;
          hi_ok    <= 1'b0;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end
      end else begin
        per_cnt <= rise ? 7'd1 : sat_inc(per_cnt);
        if (rise)      hi_cnt <= 7'd1;
        else if (fb_s) hi_cnt <= sat_inc(hi_cnt);
        if (rise) begin
          hi_ok <= 1'b0;
        end else if (fall) begin
          hi_ok     <= (hi_cnt == exp_high);
          meas_high <= hi_cnt;
        end
        if (eval) begin
          meas_period <= per_cnt;
          if (state_q == ST_ACQ) begin
            good_cnt <= period_good ? good_cnt + 4'd1 : 4'd0;
          end else if (period_good) begin
            bad_cnt <= '0;
          end else if (state_nxt == ST_ACQ) begin
            bad_cnt  <= '0;
            good_cnt <= '0;
          end else begin
            bad_cnt <= bad_cnt + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_div_monitor.sv
// Directed bench for loop_div_monitor: table of steady divider patterns plus
// hand-written lock-loss, glitch, timeout, reconfiguration and reset sequences.
module tb_loop_div_monitor;

  logic       clk = 1'b0;
  logic       rstn_s;
  logic       en;
  logic [5:0] div_n;
  logic       fb_in;
  logic       locked, meas_valid, err_period, err_timeout, cfg_err;
  logic [6:0] meas_period, meas_high;
  logic [1:0] state;

  always #5 clk = ~clk;

  loop_div_monitor #(.LOCK_CNT(8), .MISS_CNT(2)) dut (
    .clk         (clk),
    .rstn_s      (rstn_s),
    .en          (en),
    .div_n       (div_n),
    .fb_in       (fb_in),
    .locked      (locked),
    .meas_valid  (meas_valid),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .err_period  (err_period),
    .err_timeout (err_timeout),
    .cfg_err     (cfg_err),
    .state       (state)
  );

  typedef struct {
    int div; int hi; int lo; int n;
    int e_lock; int e_state; int e_mv; int e_ep; int e_p; int e_h; int e_cfg;
  } vec_t;

  vec_t tbl[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv_cnt = 0, ep_cnt = 0, et_cnt = 0;
  int last_mv_cyc = 0, tmo_cyc = 0;
  bit chk_on = 0;
  int exp_p = 0, exp_h = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; samples outputs 1ns after the edge and tallies pulses.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (meas_valid) begin
      mv_cnt++;
      last_mv_cyc = cyc;
      if (chk_on) begin
        chk("pulse_meas_period", meas_period, exp_p);
        chk("pulse_meas_high", meas_high, exp_h);
      end
    end
    if (err_period) ep_cnt++;
    if (err_timeout) begin
      et_cnt++;
      tmo_cyc = cyc;
    end
  endtask

  task automatic run(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      fb_in = 1'b1;
      repeat (hi) tick();
      fb_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic start(input int d);
    en = 1'b0; div_n = 6'(d); fb_in = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int mv0, ep0, et0;
    //          div hi lo  n lock st mv ep  p  h cfg
    tbl[0] = '{10,  5, 5,  9, 1, 3,  8, 0, 10, 5, 0};
    tbl[1] = '{10,  5, 5,  8, 0, 2,  7, 0, 10, 5, 0};
    tbl[2] = '{ 7,  4, 3, 12, 1, 3, 11, 0,  7, 4, 0};
    tbl[3] = '{ 7,  3, 4, 12, 0, 2, 11,11,  7, 3, 0};
    tbl[4] = '{10,  6, 5,  6, 0, 2,  5, 5, 11, 6, 0};
    tbl[5] = '{ 2,  1, 1, 12, 1, 3, 11, 0,  2, 1, 0};
    tbl[6] = '{63, 32,31, 10, 1, 3,  9, 0, 63,32, 0};
    tbl[7] = '{ 1,  1, 1,  8, 0, 0,  0, 0,  0, 0, 1};

    rstn_s = 1'b0; en = 1'b0; div_n = 6'd10; fb_in = 1'b0;
    #12;
    chk("rst_locked", locked, 0);
    chk("rst_state", state, 0);
    chk("rst_meas_period", meas_period, 0);
    chk("rst_pulses", {meas_valid, err_period, err_timeout, cfg_err}, 0);
    repeat (2) tick();
    rstn_s = 1'b1;
    tick();

    // Steady patterns from the table.
    foreach (tbl[i]) begin
      en = 1'b0; div_n = 6'(tbl[i].div); fb_in = 1'b0;
      repeat (4) tick();
      mv0 = mv_cnt; ep0 = ep_cnt;
      exp_p = tbl[i].e_p; exp_h = tbl[i].e_h; chk_on = 1;
      en = 1'b1;
      repeat (2) tick();
      run(tbl[i].hi, tbl[i].lo, tbl[i].n);
      repeat (3) tick();
      chk_on = 0;
      chk($sformatf("v%0d_locked", i), locked, tbl[i].e_lock);
      chk($sformatf("v%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("v%0d_valid_cnt", i), mv_cnt - mv0, tbl[i].e_mv);
      chk($sformatf("v%0d_err_cnt", i), ep_cnt - ep0, tbl[i].e_ep);
      chk($sformatf("v%0d_meas_period", i), meas_period, tbl[i].e_p);
      chk($sformatf("v%0d_meas_high", i), meas_high, tbl[i].e_h);
      chk($sformatf("v%0d_cfg_err", i), cfg_err, tbl[i].e_cfg);
    end

    // Odd ratio: lock on 4/3, then skewed 3/4 drops lock after the second bad period.
    start(7);
    run(4, 3, 12);
    chk("odd_locked", locked, 1);
    ep0 = ep_cnt;
    run(3, 4, 2);
    chk("odd_one_bad_locked", locked, 1);
    chk("odd_one_bad_err", ep_cnt - ep0, 1);
    run(3, 4, 1);
    chk("odd_two_bad_locked", locked, 0);
    chk("odd_two_bad_state", state, 2);
    chk("odd_two_bad_err", ep_cnt - ep0, 2);

    // Isolated 11-cycle glitches separated by good periods keep lock.
    start(10);
    run(5, 5, 12);
    ep0 = ep_cnt;
    run(6, 5, 1); run(5, 5, 2);
    run(6, 5, 1); run(5, 5, 2);
    repeat (3) tick();
    chk("glitch_locked", locked, 1);
    chk("glitch_state", state, 3);
    chk("glitch_err", ep_cnt - ep0, 2);
    chk("glitch_meas_period", meas_period, 10);

    // fb stuck low while locked.
    start(10);
    run(5, 5, 12);
    chk("tmo_pre_locked", locked, 1);
    et0 = et_cnt; ep0 = ep_cnt;
    for (int k = 0; k < 40 && et_cnt == et0; k++) tick();
    chk("tmo_fired", et_cnt - et0, 1);
    chk("tmo_delay", tmo_cyc - last_mv_cyc, 20);
    repeat (25) tick();
    chk("tmo_once", et_cnt - et0, 1);
    chk("tmo_state", state, 1);
    chk("tmo_locked", locked, 0);
    chk("tmo_no_period_err", ep_cnt - ep0, 0);
    run(5, 5, 12);
    repeat (3) tick();
    chk("tmo_relock", locked, 1);

    // div_n change while locked.
    start(10);
    run(5, 5, 12);
    chk("div_pre_locked", locked, 1);
    div_n = 6'd12;
    tick();
    chk("div_chg_locked", locked, 0);
    chk("div_chg_state", state, 1);
    run(6, 6, 12);
    repeat (3) tick();
    chk("div_relock", locked, 1);
    chk("div_meas_period", meas_period, 12);
    chk("div_meas_high", meas_high, 6);

    // Asynchronous reset mid-lock.
    start(10);
    run(5, 5, 12);
    chk("arst_pre_locked", locked, 1);
    #2 rstn_s = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_state", state, 0);
    chk("arst_meas", {meas_period, meas_high}, 0);
    tick();
    rstn_s = 1'b1;
    tick();
    run(5, 5, 12);
    repeat (3) tick();
    chk("arst_relock", locked, 1);

    // en dropped mid-acquire.
    start(10);
    run(5, 5, 4);
    chk("en_pre_state", state, 2);
    en = 1'b0;
    tick();
    chk("en_off_state", state, 0);
    chk("en_off_locked", locked, 0);
    chk("en_off_meas", {meas_period, meas_high}, 0);
    chk("en_off_valid", meas_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_div_monitor.md
Name: loop_div_monitor

Overview:
- Receiving-end checker for the PLL loop divider output (clko) in the clk domain.
- Measures the divided clock's period and high time in clk cycles and compares them with the programmed div_n.
- Declares lock after consecutive good periods and flags period, duty and timeout errors.
- Sits beside the loop divider and feeds PLL calibration and status logic.

Parameters:
- LOCK_CNT, 8: consecutive good periods required to assert locked (range 1..15).
- MISS_CNT, 2: consecutive bad periods in LOCKED that drop lock (range 1..3).

Ports:
- clk  in  1  system clock; same clock that drives the divider.
- rstn_s  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable.
- div_n  in  6  programmed divide ratio; quasi-static.
- fb_in  in  1  divided clock under test, treated as asynchronous data.
- locked  out  1  divider output matches div_n.
- meas_valid  out  1  one-cycle pulse; meas_period is updated.
- meas_period  out  7  clk cycles between the last two fb rising edges; saturates at 127.
- meas_high  out  7  clk cycles fb was high in the last high phase; saturates at 127.
- err_period  out  1  one-cycle pulse; a measured period/high was bad.
- err_timeout  out  1  one-cycle pulse; no fb rise within timeout.
- cfg_err  out  1  div_n < 2 (level signal).
- state  out  2  FSM state for debug.

Behaviour:
- Reset values: every output 0, all counters 0, state IDLE.
- Input conditioning: fb_in passes a 2-flop synchronizer to fb_s, then a delay flop to fb_d.
  - rise = fb_s & ~fb_d; fall = ~fb_s & fb_d.
  - Latency: the fb_in edge is first sampled at clk edge E0; registered effects of rise/fall are visible after edge E2.
- Period counter per_cnt (7b): loads 1 on rise, else increments, saturating at 127.
  - On rise: meas_period <= per_cnt, meas_valid = 1, except on the first rise after WAIT_EDGE.
- High counter hi_cnt (7b): loads 1 on rise, increments while fb_s = 1, saturating.
  - On fall: meas_high <= hi_cnt, and hi_ok <= (hi_cnt == exp_high).
- Expected values:
  - exp_period = div_n.
  - exp_high = div_n - (div_n >> 1); e.g. 10 gives 5, 7 gives 4.
  - tmo = 2*div_n, 7b.
- Good period: on a rise, meas value == exp_period AND hi_ok set by a fall since the previous rise. Otherwise the period is bad.
  - hi_ok clears on every rise.
  - Every bad period pulses err_period.
- Configuration and enable:
  - cfg_err = (div_n < 2). While cfg_err = 1, the FSM is forced to IDLE.
  - A change of div_n (registered compare) in any non-IDLE state goes to WAIT_EDGE and clears counters and locked.
- FSM states:
  - IDLE (0): locked = 0, counters cleared. Goes to WAIT_EDGE when en & ~cfg_err.
  - WAIT_EDGE (1): ignores measurements. On the first rise, arms the counters and goes to ACQUIRE.
  - ACQUIRE (2): good period → good_cnt++. Bad period → good_cnt = 0. When good_cnt reaches LOCK_CNT → LOCKED, locked = 1 registered on the same edge.
  - LOCKED (3): bad period → bad_cnt++. Good period → bad_cnt = 0. When bad_cnt reaches MISS_CNT → ACQUIRE, locked = 0, good_cnt = 0.
- Timeout: in ACQUIRE or LOCKED, per_cnt == tmo without a rise → err_timeout pulse (once), then WAIT_EDGE with locked = 0.
- en = 0 in any state → IDLE on the next edge; locked drops that edge.
- Simultaneous events:
  - en = 0 has priority over a div_n change.
  - A div_n change has priority over timeout.
  - Timeout has priority over rise evaluation.
- Asynchronous reset mid-lock: all state clears immediately; re-acquisition restarts from IDLE.

Decomposition:
- Shared package pll_pkg:
  - state encoding constants ST_IDLE, ST_WAIT, ST_ACQ, ST_LOCK;
  - counter width constant MEAS_W = 7;
  - defaults LOCK_CNT_DEF = 8, MISS_CNT_DEF = 2.
- Sub-module fb_edge_sync: 2-flop synchronizer plus edge detect, producing fb_s, rise and fall. Reusable for the reference-clock path.

Test Plan:
- Correct divider, div_n = 10, en = 1 → meas_period = 10 and meas_high = 5 on every meas_valid; locked rises on the 8th good rise after the arming edge; err_period never fires.
- Odd ratio, div_n = 7 with high 4 / low 3 → lock achieved. Then force high 3 / low 4 → err_period on each period; locked drops after the 2nd bad period.
- Single glitch while LOCKED: one period of 11 cycles with div_n = 10 → one err_period pulse; locked stays 1; bad_cnt returns to 0 on the next good period.
- fb_in stuck low while LOCKED, div_n = 10 → err_timeout exactly 20 cycles after the last rise; state → WAIT_EDGE; locked = 0; resumes and relocks when fb toggles again.
- Configuration: div_n = 1 → cfg_err = 1, state stays IDLE, no meas_valid. div_n changed 10→12 while LOCKED → locked = 0 next edge, then relock with meas_period = 12.
- rstn_s pulsed low mid-lock, and en deasserted mid-acquire → all outputs 0 immediately (reset) or next edge (en); state = IDLE.
